// File: rtl/demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// demux_1to4_stream : 1-to-4 valid/ready packet demux, route latched per packet.
// Optional feature macro: DEMUX_BEAT_CNT_EN (saturating per-channel beat counters)
// Revision: 1.0
// ============================================================================
module demux_1to4_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [1:0]          s_sel,
  input  logic                s_last,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [4*DATA_W-1:0] m_data,
  output logic [3:0]          m_last,
  output logic [3:0]          m_valid,
  input  logic [3:0]          m_ready,
  output logic                busy,
  output logic [4*CNT_W-1:0]  beat_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] route_q;
  logic [1:0] route_nxt;
  logic [1:0] route;
  logic       accept;
  logic [3:0] load;
  logic [3:0] valid_q;
  logic [3:0] last_q;

  // First beat follows s_sel; later beats of the packet reuse the latched route.
  assign route   = (state == BUSY) ? route_q : s_sel;
  assign s_ready = ~valid_q[route] | m_ready[route];
  assign accept  = s_valid & s_ready;
  assign busy    = (state == BUSY);
  assign m_valid = valid_q;
  assign m_last  = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      route_q <= 2'd0;
    end else begin
      state   <= state_nxt;
      route_q <= route_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    route_nxt = route_q;
    case (state)
      IDLE: begin
        if (accept && !s_last) begin
          state_nxt = BUSY;
          route_nxt = s_sel;
        end
      end
      BUSY: begin
        if (accept && s_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [DATA_W-1:0] data_r;
    logic              last_r;
    logic              valid_r;

    assign load[i] = accept & (route == 2'(i));

    // A load in the drain cycle keeps valid high, giving full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_r  <= '0;
        last_r  <= 1'b0;
        valid_r <= 1'b0;
      end else if (load[i]) begin
        data_r  <= s_data;
        last_r  <= s_last;
        valid_r <= 1'b1;
      end else if (m_ready[i]) begin
        valid_r <= 1'b0;
      end
    end

    assign m_data[i*DATA_W +: DATA_W] = data_r;
    assign last_q[i]                  = last_r;
    assign valid_q[i]                 = valid_r;
  end

`ifdef DEMUX_BEAT_CNT_EN
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= '0;
      end else if (load[i] && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end

    assign beat_cnt[i*CNT_W +: CNT_W] = cnt_r;
  end
`else
  assign beat_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// tb_demux_1to4_stream : table-driven and randomized checks of demux_1to4_stream.
// Revision: 1.0
// ============================================================================
module tb_demux_1to4_stream;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                clk;
  logic                rst_n;
  logic [DATA_W-1:0]   s_data;
  logic [1:0]          s_sel;
  logic                s_last;
  logic                s_valid;
  logic                s_ready;
  logic [4*DATA_W-1:0] m_data;
  logic [3:0]          m_last;
  logic [3:0]          m_valid;
  logic [3:0]          m_ready;
  logic                busy;
  logic [4*CNT_W-1:0]  beat_cnt;

  demux_1to4_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_sel(s_sel), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-channel holding slot plus "packet open" bookkeeping.
  bit         ev [4];
  logic [7:0] ed [4];
  bit         el [4];
  int         ec [4];
  bit         in_pkt;
  logic [1:0] pkt_ch;
  bit         m_acc;

  bit         n_ev [4];
  logic [7:0] n_ed [4];
  bit         n_el [4];
  int         n_ec [4];
  bit         n_in_pkt;
  logic [1:0] n_pkt_ch;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ev[i] = 0; ed[i] = 8'h00; el[i] = 0; ec[i] = 0;
    end
    in_pkt = 0;
    pkt_ch = 2'd0;
  endtask

  function automatic int exp_cnt(input int i);
`ifdef DEMUX_BEAT_CNT_EN
    return ec[i];
`else
    return 0;
`endif
  endfunction

  task automatic check_and_plan();
    int ch;
    bit rdy;
    ch  = in_pkt ? int'(pkt_ch) : int'(s_sel);
    rdy = !ev[ch] || m_ready[ch];
    m_acc = s_valid && rdy;
    chk("s_ready", {31'd0, s_ready}, {31'd0, rdy});
    chk("busy", {31'd0, busy}, {31'd0, in_pkt});
    for (int i = 0; i < 4; i++) begin
      chk("m_valid", {31'd0, m_valid[i]}, {31'd0, ev[i]});
      chk("m_data", {24'd0, m_data[i*DATA_W +: DATA_W]}, {24'd0, ed[i]});
      chk("m_last", {31'd0, m_last[i]}, {31'd0, el[i]});
      chk("beat_cnt", {30'd0, beat_cnt[i*CNT_W +: CNT_W]}, exp_cnt(i));
    end
    for (int i = 0; i < 4; i++) begin
      n_ev[i] = ev[i]; n_ed[i] = ed[i]; n_el[i] = el[i]; n_ec[i] = ec[i];
      if (ev[i] && m_ready[i]) n_ev[i] = 0;
    end
    n_in_pkt = in_pkt;
    n_pkt_ch = pkt_ch;
    if (m_acc) begin
      n_ev[ch] = 1; n_ed[ch] = s_data; n_el[ch] = s_last;
      if (ec[ch] < CNT_MAX) n_ec[ch] = ec[ch] + 1;
      if (!in_pkt && !s_last) begin
        n_in_pkt = 1;
        n_pkt_ch = s_sel;
      end else if (in_pkt && s_last) begin
        n_in_pkt = 0;
      end
    end
  endtask

  task automatic step(input logic [1:0] sel, input logic [7:0] data, input logic last,
                      input logic valid, input logic [3:0] rdy);
    s_sel = sel; s_data = data; s_last = last; s_valid = valid; m_ready = rdy;
    #2;
    check_and_plan();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      ev[i] = n_ev[i]; ed[i] = n_ed[i]; el[i] = n_el[i]; ec[i] = n_ec[i];
    end
    in_pkt = n_in_pkt;
    pkt_ch = n_pkt_ch;
  endtask

  // Asynchronous reset asserted and checked between clock edges.
  task automatic mid_reset();
    s_valid = 1'b0; m_ready = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", {28'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
    logic       valid;
    logic [3:0] rdy;
    logic       exp_ready;
    logic [3:0] exp_valid;
    logic       exp_busy;
    logic [1:0] chk_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [1:0] r_sel;
    logic [7:0] r_data;
    logic       r_last;
    logic       r_valid;
    bit         pending;

    tbl[0]  = '{2'd0, 8'hA0, 1'b1, 1'b1, 4'hF,    1'b1, 4'b0001, 1'b0, 2'd0, 8'hA0};
    tbl[1]  = '{2'd1, 8'hA1, 1'b1, 1'b1, 4'hF,    1'b1, 4'b0010, 1'b0, 2'd1, 8'hA1};
    tbl[2]  = '{2'd2, 8'hA2, 1'b1, 1'b1, 4'hF,    1'b1, 4'b0100, 1'b0, 2'd2, 8'hA2};
    tbl[3]  = '{2'd3, 8'hA3, 1'b1, 1'b1, 4'hF,    1'b1, 4'b1000, 1'b0, 2'd3, 8'hA3};
    tbl[4]  = '{2'd2, 8'h11, 1'b0, 1'b1, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 8'h11};
    tbl[5]  = '{2'd1, 8'h22, 1'b0, 1'b1, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2, 8'h22};
    tbl[6]  = '{2'd3, 8'h33, 1'b1, 1'b1, 4'hF,    1'b1, 4'b0100, 1'b0, 2'd2, 8'h33};
    tbl[7]  = '{2'd0, 8'h00, 1'b0, 1'b0, 4'hF,    1'b1, 4'b0000, 1'b0, 2'd2, 8'h33};
    tbl[8]  = '{2'd1, 8'h55, 1'b1, 1'b1, 4'b1101, 1'b1, 4'b0010, 1'b0, 2'd1, 8'h55};
    tbl[9]  = '{2'd1, 8'h66, 1'b1, 1'b1, 4'b1101, 1'b0, 4'b0010, 1'b0, 2'd1, 8'h55};
    tbl[10] = '{2'd3, 8'h77, 1'b1, 1'b1, 4'b1101, 1'b1, 4'b1010, 1'b0, 2'd3, 8'h77};
    tbl[11] = '{2'd0, 8'h00, 1'b0, 1'b0, 4'hF,    1'b1, 4'b0000, 1'b0, 2'd3, 8'h77};

    rst_n = 1'b0; s_data = 8'h00; s_sel = 2'd0; s_last = 1'b0; s_valid = 1'b0; m_ready = 4'hF;
    model_reset();
    #12;
    chk("reset_m_valid", {28'd0, m_valid}, 32'd0);
    chk("reset_m_data", m_data, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int k = 0; k < 12; k++) begin
      s_sel = tbl[k].sel; s_data = tbl[k].data; s_last = tbl[k].last;
      s_valid = tbl[k].valid; m_ready = tbl[k].rdy;
      #2;
      chk("tbl_s_ready", {31'd0, s_ready}, {31'd0, tbl[k].exp_ready});
      step(tbl[k].sel, tbl[k].data, tbl[k].last, tbl[k].valid, tbl[k].rdy);
      chk("tbl_m_valid", {28'd0, m_valid}, {28'd0, tbl[k].exp_valid});
      chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[k].exp_busy});
      chk("tbl_m_data", {24'd0, m_data[tbl[k].chk_ch*DATA_W +: DATA_W]}, {24'd0, tbl[k].exp_data});
    end

    // Back-to-back 8-beat packet on channel 0: no bubbles, last only on beat 8.
    for (int k = 0; k < 8; k++) begin
      step(2'd0, 8'hC0 + 8'(k), (k == 7), 1'b1, 4'hF);
      chk("b2b_valid0", {31'd0, m_valid[0]}, 32'd1);
      chk("b2b_last0", {31'd0, m_last[0]}, (k == 7) ? 32'd1 : 32'd0);
      chk("b2b_data0", {24'd0, m_data[7:0]}, 32'hC0 + k);
    end
    step(2'd0, 8'h00, 1'b0, 1'b0, 4'hF);

    // Reset in the middle of a packet; the following beat starts a new packet.
    step(2'd2, 8'h5A, 1'b0, 1'b1, 4'b1011);
    chk("midpkt_busy", {31'd0, busy}, 32'd1);
    mid_reset();
    step(2'd1, 8'h3C, 1'b1, 1'b1, 4'hF);
    chk("post_rst_ch1", {24'd0, m_data[15:8]}, 32'h3C);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Randomized traffic; a refused beat is held until taken.
    pending = 0;
    r_sel = 2'd0; r_data = 8'h00; r_last = 1'b0; r_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!pending) begin
        r_sel   = 2'($urandom_range(0, 3));
        r_data  = 8'($urandom);
        r_last  = ($urandom_range(0, 2) == 0);
        r_valid = ($urandom_range(0, 3) != 0);
      end
      step(r_sel, r_data, r_last, r_valid, 4'($urandom));
      pending = r_valid && !m_acc;
    end

    // Counter saturation: five beats into channel 3 after a reset.
    mid_reset();
    for (int k = 0; k < 5; k++) step(2'd3, 8'h90 + 8'(k), 1'b1, 1'b1, 4'hF);
    step(2'd0, 8'h00, 1'b0, 1'b0, 4'hF);
`ifdef DEMUX_BEAT_CNT_EN
    chk("cnt_sat_ch3", {30'd0, beat_cnt[7:6]}, 32'd3);
`else
    chk("cnt_off_ch3", {30'd0, beat_cnt[7:6]}, 32'd0);
`endif
    chk("cnt_other", {26'd0, beat_cnt[5:0]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
